// File: rtl/taillight_pattern_monitor_pkg.sv
// Shared definitions for the tail-light sequencer and its receive-side monitor:
// state encoding, legal lamp frames, mode and error codes, and frame-decode helpers.
package taillight_pattern_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_H_ON = 3'd7
  } state_t;

  // Lamp order is {LC,LB,LA,RA,RB,RC}
  localparam logic [5:0] FR_DARK = 6'b000000;
  localparam logic [5:0] FR_L1   = 6'b001000;
  localparam logic [5:0] FR_L2   = 6'b011000;
  localparam logic [5:0] FR_L3   = 6'b111000;
  localparam logic [5:0] FR_R1   = 6'b000100;
  localparam logic [5:0] FR_R2   = 6'b000110;
  localparam logic [5:0] FR_R3   = 6'b000111;
  localparam logic [5:0] FR_HAZ  = 6'b111111;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_HAZ   = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FRAME   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic state_t start_decode(input logic [5:0] f);
    case (f)
      FR_L1:   return ST_L1;
      FR_R1:   return ST_R1;
      FR_HAZ:  return ST_H_ON;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic logic is_start_frame(input logic [5:0] f);
    return (f == FR_DARK) || (f == FR_L1) || (f == FR_R1) || (f == FR_HAZ);
  endfunction

  // Frame that must arrive next for a sequence in state s to advance
  function automatic logic [5:0] expected_frame(input state_t s);
    case (s)
      ST_L1:   return FR_L2;
      ST_L2:   return FR_L3;
      ST_R1:   return FR_R2;
      ST_R2:   return FR_R3;
      default: return FR_DARK;
    endcase
  endfunction

  function automatic state_t advance(input state_t s);
    case (s)
      ST_L1:   return ST_L2;
      ST_L2:   return ST_L3;
      ST_R1:   return ST_R2;
      ST_R2:   return ST_R3;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] state_mode(input state_t s);
    case (s)
      ST_L1, ST_L2, ST_L3: return MODE_LEFT;
      ST_R1, ST_R2, ST_R3: return MODE_RIGHT;
      ST_H_ON:             return MODE_HAZ;
      default:             return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/taillight_pattern_monitor_tick_watchdog.sv
// Stall detector: counts clocks since the last kick while enabled and pulses
// expire on the cycle the count sits at TIMEOUT_CYC-1 with no kick.
module tick_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic kick,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_count;

  // A kick on the expiry edge wins, so expire is masked by kick
  assign expire = enable && !kick && (r_count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (kick || !enable || expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/taillight_pattern_monitor.sv
// Receive-side checker for the tail-light sequencer: decodes the running sequence
// from lamp frames sampled on tick, flags bad frames and stalls, counts errors.
module taillight_pattern_monitor
  import taillight_pattern_monitor_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [5:0]       lamps,
  input  logic             err_clr,
  output logic [1:0]       mode,
  output logic             seq_done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       dbg_state
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_expire;
  logic             w_bad;
  logic             w_done;
  logic             w_timeout;
  logic [1:0]       w_mode_nxt;
  logic             w_err_nxt;
  logic [1:0]       w_code_nxt;
  logic [1:0]       r_mode;
  logic             r_seq_done;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [CNT_W-1:0] r_err_count;

  tick_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .kick   (tick),
    .enable (r_state != ST_IDLE),
    .expire (w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A mismatched frame resyncs through the idle start decode of that same frame
  always_comb begin
    w_state_nxt = r_state;
    w_bad       = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    if (tick) begin
      if (r_state == ST_IDLE) begin
        w_state_nxt = start_decode(lamps);
        w_bad       = !is_start_frame(lamps);
      end else if (lamps == expected_frame(r_state)) begin
        w_state_nxt = advance(r_state);
        w_done      = (w_state_nxt == ST_IDLE);
      end else begin
        w_state_nxt = start_decode(lamps);
        w_bad       = 1'b1;
      end
    end else if (w_expire) begin
      w_state_nxt = ST_IDLE;
      w_timeout   = 1'b1;
    end
  end

  always_comb begin
    w_mode_nxt = state_mode(w_state_nxt);
    w_err_nxt  = w_bad || w_timeout;
    w_code_nxt = ERR_NONE;
    if (w_bad)          w_code_nxt = ERR_FRAME;
    else if (w_timeout) w_code_nxt = ERR_TIMEOUT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode      <= MODE_IDLE;
      r_seq_done  <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_count <= '0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_seq_done <= w_done;
      r_err      <= w_err_nxt;
      r_err_code <= w_code_nxt;
      if (err_clr)
        r_err_count <= '0;
      else if (w_err_nxt && (r_err_count != '1))
        r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign mode      = r_mode;
  assign seq_done  = r_seq_done;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign err_count = r_err_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_taillight_pattern_monitor.sv
// Bench for taillight_pattern_monitor: directed scenarios with literal expectations
// plus a randomized run checked against a frame-queue reference model.
module tb_taillight_pattern_monitor;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] lamps = '0;
  logic       err_clr = 1'b0;

  logic [1:0] mode, mode2;
  logic       seq_done, seq_done2;
  logic       err, err2;
  logic [1:0] err_code, err_code2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic [2:0] dbg_state, dbg_state2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining frames of the running sequence
  logic [5:0] seq_q[$];
  int         m_kind;
  int         m_idle;
  logic [1:0] exp_mode;
  logic       exp_done;
  logic       exp_err;
  logic [1:0] exp_code;
  int         exp_cnt8;
  int         exp_cnt2;

  taillight_pattern_monitor #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .lamps(lamps), .err_clr(err_clr),
    .mode(mode), .seq_done(seq_done), .err(err), .err_code(err_code),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  taillight_pattern_monitor #(.TIMEOUT_CYC(TO), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .lamps(lamps), .err_clr(err_clr),
    .mode(mode2), .seq_done(seq_done2), .err(err2), .err_code(err_code2),
    .err_count(err_count2), .dbg_state(dbg_state2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    seq_q.delete();
    m_kind = 0; m_idle = 0;
    exp_mode = 2'b00; exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'b00;
    exp_cnt8 = 0; exp_cnt2 = 0;
  endtask

  task automatic model_start(input logic [5:0] f, output logic legal);
    legal = 1'b1;
    seq_q.delete();
    m_kind = 0;
    case (f)
      6'b001000: begin seq_q = '{6'b011000, 6'b111000, 6'b000000}; m_kind = 1; end
      6'b000100: begin seq_q = '{6'b000110, 6'b000111, 6'b000000}; m_kind = 2; end
      6'b111111: begin seq_q = '{6'b000000}; m_kind = 3; end
      6'b000000: ;
      default:   legal = 1'b0;
    endcase
  endtask

  task automatic model_step(input logic t, input logic [5:0] l, input logic clr);
    logic legal;
    exp_done = 1'b0;
    exp_code = 2'b00;
    if (t) begin
      m_idle = 0;
      if (seq_q.size() == 0) begin
        model_start(l, legal);
        if (!legal) exp_code = 2'b01;
      end else if (l == seq_q[0]) begin
        void'(seq_q.pop_front());
        if (seq_q.size() == 0) begin exp_done = 1'b1; m_kind = 0; end
      end else begin
        model_start(l, legal);
        exp_code = 2'b01;
      end
    end else if (seq_q.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        seq_q.delete(); m_kind = 0; m_idle = 0;
        exp_code = 2'b10;
      end
    end
    exp_err  = (exp_code != 2'b00);
    exp_mode = (seq_q.size() == 0) ? 2'b00 : 2'(m_kind);
    if (clr) begin
      exp_cnt8 = 0; exp_cnt2 = 0;
    end else if (exp_err) begin
      if (exp_cnt8 < 255) exp_cnt8++;
      if (exp_cnt2 < 3)   exp_cnt2++;
    end
  endtask

  task automatic drive(input logic t, input logic [5:0] l, input logic clr);
    @(negedge clk);
    tick = t; lamps = l; err_clr = clr;
    @(posedge clk);
    model_step(t, l, clr);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; tick = 1'b0; lamps = '0; err_clr = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; tick = 1'b0; lamps = '0; err_clr = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({mode, seq_done, err, err_code, err_count, err_count2, dbg_state} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset: got mode=%b done=%b err=%b code=%b cnt=%0d cnt2=%0d st=%0d, expected all zero",
               mode, seq_done, err, err_code, err_count, err_count2, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_left();
    logic [5:0] fr [4] = '{6'b001000, 6'b011000, 6'b111000, 6'b000000};
    logic [1:0] md [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fr[i], 1'b0);
      n_checks++;
      if ({mode, seq_done, err} !== {md[i], (i == 3), 1'b0}) begin
        n_errors++;
        $display("FAIL left step%0d: got mode=%b done=%b err=%b, expected mode=%b done=%b err=0",
                 i, mode, seq_done, err, md[i], (i == 3));
      end
    end
  endtask

  task automatic test_right_hazard();
    logic [5:0] fr [6] = '{6'b000100, 6'b000110, 6'b000111, 6'b000000, 6'b111111, 6'b000000};
    logic [1:0] md [6] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, fr[i], 1'b0);
      n_checks++;
      if ({mode, seq_done, err} !== {md[i], (i == 3 || i == 5), 1'b0}) begin
        n_errors++;
        $display("FAIL right_hazard step%0d: got mode=%b done=%b err=%b, expected mode=%b done=%b err=0",
                 i, mode, seq_done, err, md[i], (i == 3 || i == 5));
      end
    end
    n_checks++;
    if (err_count !== 8'd0) begin
      n_errors++;
      $display("FAIL right_hazard count: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_resync();
    apply_reset();
    drive(1'b1, 6'b001000, 1'b0);
    drive(1'b1, 6'b011000, 1'b0);
    drive(1'b1, 6'b000100, 1'b0);
    n_checks++;
    if ({err, err_code, mode, seq_done, err_count} !== {1'b1, 2'b01, 2'b10, 1'b0, 8'd1}) begin
      n_errors++;
      $display("FAIL resync: got err=%b code=%b mode=%b done=%b cnt=%0d, expected err=1 code=01 mode=10 done=0 cnt=1",
               err, err_code, mode, seq_done, err_count);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    drive(1'b1, 6'b001000, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      drive(1'b0, 6'b000000, 1'b0);
      if (k < TO) begin
        if (err !== 1'b0 || mode !== 2'b01) begin
          n_checks++; n_errors++;
          $display("FAIL timeout_early clk%0d: got err=%b mode=%b, expected err=0 mode=01", k, err, mode);
        end
      end else begin
        n_checks++;
        if ({err, err_code, mode} !== {1'b1, 2'b10, 2'b00}) begin
          n_errors++;
          $display("FAIL timeout_fire: got err=%b code=%b mode=%b, expected err=1 code=10 mode=00",
                   err, err_code, mode);
        end
      end
    end
    drive(1'b0, 6'b000000, 1'b0);
    n_checks++;
    if ({err, err_code} !== 3'b000) begin
      n_errors++;
      $display("FAIL timeout_pulse: got err=%b code=%b, expected err=0 code=00", err, err_code);
    end
    // Tick one clk before expiry
    drive(1'b1, 6'b001000, 1'b0);
    for (int k = 1; k < TO - 1; k++) drive(1'b0, 6'b000000, 1'b0);
    drive(1'b1, 6'b011000, 1'b0);
    n_checks++;
    if ({err, mode} !== {1'b0, 2'b01}) begin
      n_errors++;
      $display("FAIL timeout_tick63: got err=%b mode=%b, expected err=0 mode=01", err, mode);
    end
    // Tick exactly on the expiry edge
    for (int k = 1; k < TO; k++) drive(1'b0, 6'b000000, 1'b0);
    drive(1'b1, 6'b111000, 1'b0);
    n_checks++;
    if ({err, mode} !== {1'b0, 2'b01}) begin
      n_errors++;
      $display("FAIL timeout_tick64: got err=%b mode=%b, expected err=0 mode=01", err, mode);
    end
    drive(1'b1, 6'b000000, 1'b0);
    n_checks++;
    if ({seq_done, err, mode} !== {1'b1, 1'b0, 2'b00}) begin
      n_errors++;
      $display("FAIL timeout_done: got done=%b err=%b mode=%b, expected done=1 err=0 mode=00",
               seq_done, err, mode);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'b010101, 1'b0);
      n_checks++;
      if ({err, err_code, mode, err_count2, err_count} !==
          {1'b1, 2'b01, 2'b00, 2'((i + 1 > 3) ? 3 : i + 1), 8'(i + 1)}) begin
        n_errors++;
        $display("FAIL saturate%0d: got err=%b code=%b mode=%b cnt2=%0d cnt8=%0d, expected err=1 code=01 mode=00 cnt2=%0d cnt8=%0d",
                 i, err, err_code, mode, err_count2, err_count, (i + 1 > 3) ? 3 : i + 1, i + 1);
      end
    end
    drive(1'b1, 6'b010101, 1'b1);
    n_checks++;
    if ({err, err_code, err_count2, err_count} !== {1'b1, 2'b01, 2'd0, 8'd0}) begin
      n_errors++;
      $display("FAIL clr_vs_err: got err=%b code=%b cnt2=%0d cnt8=%0d, expected err=1 code=01 counts 0",
               err, err_code, err_count2, err_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b1, 6'b001000, 1'b0);
    drive(1'b1, 6'b011000, 1'b0);
    drive(1'b1, 6'b010101, 1'b0);
    drive(1'b1, 6'b001000, 1'b0);
    drive(1'b1, 6'b011000, 1'b0);
    #2;
    reset = 1'b1; tick = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({mode, seq_done, err, err_code, err_count, err_count2} !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_mid: got mode=%b done=%b err=%b code=%b cnt=%0d, expected all zero",
               mode, seq_done, err, err_code, err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 6'b011000, 1'b0);
    n_checks++;
    if ({err, err_code, mode} !== {1'b1, 2'b01, 2'b00}) begin
      n_errors++;
      $display("FAIL reset_mid_next: got err=%b code=%b mode=%b, expected err=1 code=01 mode=00",
               err, err_code, mode);
    end
  endtask

  task automatic test_random();
    logic [5:0] tbl [8] = '{6'b000000, 6'b001000, 6'b011000, 6'b111000,
                            6'b000100, 6'b000110, 6'b000111, 6'b111111};
    logic [5:0] f;
    logic       clr;
    int         gap;
    apply_reset();
    for (int it = 0; it < 400; it++) begin
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 68) : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 6'($urandom_range(0, 63)), ($urandom_range(0, 49) == 0));
        n_checks++;
        if ({mode, seq_done, err, err_code, err_count, err_count2} !==
            {exp_mode, exp_done, exp_err, exp_code, exp_cnt8[7:0], exp_cnt2[1:0]}) begin
          n_errors++;
          $display("FAIL random_gap it%0d: got mode=%b done=%b err=%b code=%b cnt=%0d cnt2=%0d, expected %b %b %b %b %0d %0d",
                   it, mode, seq_done, err, err_code, err_count, err_count2,
                   exp_mode, exp_done, exp_err, exp_code, exp_cnt8, exp_cnt2);
        end
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: f = (seq_q.size() != 0) ? seq_q[0] : tbl[$urandom_range(0, 7)];
        6, 7:             f = tbl[$urandom_range(0, 7)];
        default:          f = 6'($urandom_range(0, 63));
      endcase
      clr = ($urandom_range(0, 29) == 0);
      drive(1'b1, f, clr);
      n_checks++;
      if ({mode, seq_done, err, err_code, err_count, err_count2} !==
          {exp_mode, exp_done, exp_err, exp_code, exp_cnt8[7:0], exp_cnt2[1:0]}) begin
        n_errors++;
        $display("FAIL random_tick it%0d frame=%b: got mode=%b done=%b err=%b code=%b cnt=%0d cnt2=%0d, expected %b %b %b %b %0d %0d",
                 it, f, mode, seq_done, err, err_code, err_count, err_count2,
                 exp_mode, exp_done, exp_err, exp_code, exp_cnt8, exp_cnt2);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_left();
    test_right_hazard();
    test_resync();
    test_timeout();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
